cv3_layer_ctrl: RTL and testbench

CV3_LAYER_CTRL -- requirements
Module: cv3_layer_ctrl

---
 rtl/cv3_layer_ctrl.sv | 148 ++++++++++++++
 tb/tb_cv3_layer_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cv3_layer_ctrl.sv
// Layer-pass sequencer for a conv channel datapath: loads the kernel, streams input columns, collects output columns.
// Optional perf_cycles busy-cycle counter is built when CV3_CTRL_PERF_EN is defined.
module cv3_layer_ctrl #(
  parameter int IMG_WIDTH    = 12,
  parameter int KERNEL_SIZE  = 3,
  parameter int OUT_CHANNELS = 8,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pause,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] kern_addr,
  output logic [ADDR_WIDTH-1:0] col_addr,
  output logic                  kernel_load,
  output logic                  valid_in,
  input  logic                  dp_valid_out,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr
`ifdef CV3_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int OUT_COLS = IMG_WIDTH - KERNEL_SIZE + 1;
  localparam int CH_W     = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int K_W      = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int OC_W     = $clog2(OUT_COLS + 1);

  localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(OUT_CHANNELS - 1);
  localparam logic [K_W-1:0]        LAST_K   = K_W'(KERNEL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [OC_W-1:0]       LAST_OC  = OC_W'(OUT_COLS - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_K, STREAM, DRAIN, NEXT_CH, DONE
  } state_t;

  state_t          state;
  logic [CH_W-1:0] ch;
  logic [K_W-1:0]  k;
  logic [OC_W-1:0] out_col;
  logic            ch_full;   // all output columns of the current channel have been written

  function automatic logic [ADDR_WIDTH-1:0] kern_base(input logic [CH_W-1:0] c);
    return ADDR_WIDTH'(int'(c) * KERNEL_SIZE);
  endfunction

  // Gated by busy so stray datapath pulses between passes never reach the buffer.
  assign out_we   = dp_valid_out & busy;
  assign out_addr = ADDR_WIDTH'(int'(ch) * OUT_COLS + int'(out_col));

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block override earlier defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= '0;
      k           <= '0;
      out_col     <= '0;
      ch_full     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      kernel_load <= 1'b0;
      valid_in    <= 1'b0;
      kern_addr   <= '0;
      col_addr    <= '0;
    end else begin
      kernel_load <= 1'b0;
      valid_in    <= 1'b0;
      done        <= 1'b0;

      if (out_we) begin
        out_col <= (out_col == LAST_OC) ? '0 : out_col + 1'b1;
        if (out_col == LAST_OC) ch_full <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD_K;
            busy      <= 1'b1;
            ch        <= '0;
            k         <= '0;
            kern_addr <= '0;
            col_addr  <= '0;
            out_col   <= '0;
            ch_full   <= 1'b0;
          end
        end
        LOAD_K: begin
          // Memory read latency is one cycle, so the strobe trails its address.
          kernel_load <= 1'b1;
          if (k == LAST_K) begin
            k     <= '0;
            state <= STREAM;
          end else begin
            k         <= k + 1'b1;
            kern_addr <= kern_addr + 1'b1;
          end
        end
        STREAM: begin
          if (!pause) begin
            valid_in <= 1'b1;
            if (col_addr == LAST_COL) begin
              col_addr <= '0;
              state    <= DRAIN;
            end else begin
              col_addr <= col_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (ch_full || (out_we && out_col == LAST_OC)) state <= NEXT_CH;
        end
        NEXT_CH: begin
          ch_full <= 1'b0;
          if (ch == LAST_CH) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            ch        <= ch + 1'b1;
            kern_addr <= kern_base(ch + 1'b1);
            state     <= LOAD_K;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CV3_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= '0;
    end else if (busy && perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cv3_layer_ctrl.sv
// Self-checking bench for cv3_layer_ctrl: event timelines from a cycle-level pass model versus monitored DUT events.
// Build with CV3_CTRL_PERF_EN defined to also check perf_cycles.
module tb_cv3_layer_ctrl;
  localparam int W  = 12;
  localparam int K  = 3;
  localparam int NC = 8;
  localparam int AW = 8;
  localparam int OW = W - K + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0, dp_valid_out = 1'b0;
  logic busy, done, kernel_load, valid_in, out_we;
  logic [AW-1:0] kern_addr, col_addr, out_addr;
`ifdef CV3_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  cv3_layer_ctrl #(.IMG_WIDTH(W), .KERNEL_SIZE(K), .OUT_CHANNELS(NC), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .busy(busy), .done(done),
    .kern_addr(kern_addr), .col_addr(col_addr), .kernel_load(kernel_load), .valid_in(valid_in),
    .dp_valid_out(dp_valid_out), .out_we(out_we), .out_addr(out_addr)
`ifdef CV3_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, failed = 0;
  int cyc = 0;
  int dp_due[$];
  bit dp_force = 1'b0;
  bit pat [1024];

  // Datapath stand-in: drives valid_out in the cycle for which a pulse was scheduled.
  always @(posedge clk) begin
    cyc++;
    #1;
    dp_valid_out = dp_force || (dp_due.size() > 0 && dp_due[0] == cyc);
    if (dp_due.size() > 0 && dp_due[0] == cyc) void'(dp_due.pop_front());
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int ev(input int t, input int a);
    return t * 1024 + a;
  endfunction

  task automatic cmp_q(input string tag, input int obs[$], input int exp[$]);
    int n;
    check({tag, "_count"}, obs.size(), exp.size());
    n = (obs.size() < exp.size()) ? obs.size() : exp.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_kload"}, kernel_load, 0);
    check({tag, "_vin"}, valid_in, 0);
    check({tag, "_we"}, out_we, 0);
    check({tag, "_kaddr"}, kern_addr, 0);
    check({tag, "_caddr"}, col_addr, 0);
    check({tag, "_oaddr"}, out_addr, 0);
  endtask

  // One pass: model the expected timeline from the pause pattern, then run and compare.
  // d delays the final datapath pulse; xstart is a relative cycle for a redundant start.
  task automatic run_pass(input string tag, input int d, input int xstart);
    int exp_kl[$], exp_vi[$], exp_ow[$], obs_kl[$], obs_vi[$], obs_ow[$];
    int r, tp, exp_busy, n0, vin_ch, vin_tot, busy_cnt, done_cnt, done_rel, post, prev_ka, prev_ca;
    bit seen;

    r = 0;
    tp = 0;
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < K; k++) exp_kl.push_back(ev(r + k + 1, c * K + k));
      r += K;
      for (int i = 0; i < W; ) begin
        if (pat[r]) begin
          r++;
        end else begin
          exp_vi.push_back(ev(r + 1, i));
          if (i >= 2) begin
            tp = r + 2 + ((c == NC - 1 && i == W - 1) ? d : 0);
            exp_ow.push_back(ev(tp, c * OW + i - 2));
          end
          i++;
          r++;
        end
      end
      r = tp + 2;
    end
    exp_busy = r;

    dp_due.delete();
    vin_ch = 0; vin_tot = 0; busy_cnt = 0; done_cnt = 0; done_rel = -1;
    post = 0; seen = 0; prev_ka = 0; prev_ca = 0;

    @(negedge clk);
    start = 1'b1;
    n0 = cyc + 1;
    for (int i = 0; i < 1500 && post < 4; i++) begin
      @(negedge clk);
      r = cyc - n0;
      pause = pat[r];
      start = (r == xstart);
      if (kernel_load) begin
        obs_kl.push_back(ev(r, prev_ka));
        vin_ch = 0;
      end
      if (valid_in) begin
        obs_vi.push_back(ev(r, prev_ca));
        vin_ch++;
        vin_tot++;
        if (vin_ch >= 3) dp_due.push_back(cyc + 1 + ((vin_tot == NC * W) ? d : 0));
      end
      if (out_we) obs_ow.push_back(ev(r, int'(out_addr)));
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_rel = r;
        seen = 1'b1;
      end
      if (seen) post++;
      prev_ka = int'(kern_addr);
      prev_ca = int'(col_addr);
    end
    pause = 1'b0;
    start = 1'b0;

    cmp_q({tag, "_kload"}, obs_kl, exp_kl);
    cmp_q({tag, "_vin"}, obs_vi, exp_vi);
    cmp_q({tag, "_outwe"}, obs_ow, exp_ow);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_rel, exp_busy);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
`ifdef CV3_CTRL_PERF_EN
    check({tag, "_perf_held"}, perf_cycles, exp_busy);
`endif
  endtask

  initial begin
    int busy_cnt, done_cnt, we_cnt;

    // Reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
`ifdef CV3_CTRL_PERF_EN
    check("reset_perf", perf_cycles, 0);
`endif
    rst = 1'b0;

    // Baseline pass: no pause, immediate datapath
    for (int i = 0; i < 1024; i++) pat[i] = 1'b0;
    run_pass("base", 0, -1);

    // Four-cycle pause at column 5 of channel 0, redundant start at cycle 20
    for (int i = 0; i < 1024; i++) pat[i] = 1'b0;
    for (int i = K + 5; i < K + 9; i++) pat[i] = 1'b1;
    run_pass("pause4", 0, 20);

    // Random pauses everywhere, last pulse of the final channel delayed 5 cycles
    for (int i = 0; i < 1024; i++) pat[i] = ($urandom_range(0, 3) == 0);
    run_pass("rand_late", 5, -1);

    // Abort mid channel 3 stream (channel 3 streams from cycle 57 with no pauses)
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check_zero("abort");
    dp_due.delete();
    @(negedge clk);
    rst = 1'b0;

    // Idle with datapath pulses: nothing written, counter untouched
    busy_cnt = 0; done_cnt = 0; we_cnt = 0;
    dp_force = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (out_we) we_cnt++;
    end
    dp_force = 1'b0;
    @(negedge clk);
    check("idle_busy", busy_cnt, 0);
    check("idle_done", done_cnt, 0);
    check("idle_we", we_cnt, 0);
    check("idle_oaddr", out_addr, 0);

    // Fresh pass after abort with random pauses must restart from channel 0
    for (int i = 0; i < 1024; i++) pat[i] = ($urandom_range(0, 4) == 0);
    run_pass("after_abort", 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
